// File: rtl/sobel_frame_ctrl.sv
`timescale 1ns/1ps
// sobel_frame_ctrl
//   Frame sequencer for the Sobel edge pipeline. On start it reads every pixel
//   of one frame from the input frame buffer and presents it to the pipeline's
//   camera-side inputs. It writes each returned result to the output buffer at
//   sequential addresses. It reports completion, or a timeout if the pipeline
//   does not return every pixel.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start_i             frame start request, sampled only while idle
//   hold_i              frame-buffer arbiter busy, suppresses read issue
//   busy_o              high while feeding or draining a frame
//   frame_done_o        one-cycle pulse on successful completion
//   err_timeout_o       sticky timeout flag, cleared by the next accepted start
//   rd_en_o, rd_addr_o  frame-buffer read strobe and address
//   rd_data_i           {R,G,B}, valid one cycle after rd_en_o
//   cam_*_o             pixel and per-pixel valid strobe to the pipeline
//   sobel_red_i         pipeline result (red channel is used)
//   sobel_done_i        per-pixel result strobe
//   wr_en_o, wr_addr_o, wr_data_o   output-buffer write port
module sobel_frame_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              err_timeout_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [23:0]       rd_data_i,
    output logic [7:0]        cam_red_o,
    output logic [7:0]        cam_green_o,
    output logic [7:0]        cam_blue_o,
    output logic              cam_done_o,
    input  logic [7:0]        sobel_red_i,
    input  logic              sobel_done_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);

    // Counters carry one extra bit so they can hold N even when N == 2^ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] PIX_N    = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic start_acc;
    logic issue;
    logic capture;
    logic timeout_hit;
    logic rd_en_d1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        timeout_hit = 1'b0;
        issue       = (state == ST_FEED) && !hold_i && (rd_cnt < PIX_N);
        capture     = ((state == ST_FEED) || (state == ST_DRAIN)) &&
                      sobel_done_i && (out_cnt < PIX_N);
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_FEED;
                    start_acc = 1'b1;
                end
            end
            ST_FEED: begin
                if (issue && (rd_cnt == PIX_LAST)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (out_cnt == PIX_N) begin
                    state_nxt = ST_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt        <= '0;
            out_cnt       <= '0;
            to_cnt        <= '0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            if (start_acc) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                if (issue) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (capture) begin
                    out_cnt <= out_cnt + 1'b1;
                end
                if (state == ST_DRAIN) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            busy_o       <= (state_nxt == ST_FEED) || (state_nxt == ST_DRAIN);
            frame_done_o <= (state_nxt == ST_DONE);

            if (timeout_hit) begin
                err_timeout_o <= 1'b1;
            end else if (start_acc) begin
                err_timeout_o <= 1'b0;
            end
        end
    end

    // Read issue and feed path. Read data arrives the cycle after rd_en_o,
    // so the strobe is delayed twice to land together with the loaded pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            rd_en_d1    <= 1'b0;
            cam_done_o  <= 1'b0;
            cam_red_o   <= '0;
            cam_green_o <= '0;
            cam_blue_o  <= '0;
        end else begin
            rd_en_o <= issue;
            if (issue) begin
                rd_addr_o <= rd_cnt[ADDR_W-1:0];
            end
            rd_en_d1   <= rd_en_o;
            cam_done_o <= rd_en_d1;
            if (rd_en_d1) begin
                cam_red_o   <= rd_data_i[23:16];
                cam_green_o <= rd_data_i[15:8];
                cam_blue_o  <= rd_data_i[7:0];
            end
        end
    end

    // Capture path: one registered write per accepted result strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            wr_en_o <= capture;
            if (capture) begin
                wr_addr_o <= out_cnt[ADDR_W-1:0];
                wr_data_o <= sobel_red_i;
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;

    localparam int N   = 12;
    localparam int TMO = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          hold_i;
    logic          busy_o;
    logic          frame_done_o;
    logic          err_timeout_o;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [23:0]   rd_data_i;
    logic [7:0]    cam_red_o;
    logic [7:0]    cam_green_o;
    logic [7:0]    cam_blue_o;
    logic          cam_done_o;
    logic [7:0]    sobel_red_i;
    logic          sobel_done_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .IMG_W  (4),
        .IMG_H  (3),
        .ADDR_W (AW),
        .TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .hold_i       (hold_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .err_timeout_o(err_timeout_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .cam_red_o    (cam_red_o),
        .cam_green_o  (cam_green_o),
        .cam_blue_o   (cam_blue_o),
        .cam_done_o   (cam_done_o),
        .sobel_red_i  (sobel_red_i),
        .sobel_done_i (sobel_done_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o)
    );

    // One frame scenario with the outcome predicted from the frame rules:
    // every result not dropped is written once, a complete frame pulses
    // frame_done_o, an incomplete one raises err_timeout_o.
    typedef struct {
        int hold_at;
        int hold_len;
        int hold_pct;
        int drop_last;
        int extra_after;
        bit extra_idle;
        bit start_busy;
        int exp_writes;
        int exp_done;
        bit exp_err;
    } scen_t;

    typedef struct {
        int         due;
        logic [7:0] val;
    } ret_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [23:0] mem [N];
    ret_t        pq[$];
    int          rd_cyc[$];

    int n_reads = 0, n_cam = 0, n_wr = 0, n_done = 0;
    int last_addr = 0, prev_addr = 0, gap = 0, max_gap = 0;
    int last_read_cyc = 0, last_wr_cyc = 0, done_cyc = 0, err_cyc = 0;
    bit prev_rd_en = 1'b0, err_seen = 1'b0, idle_strobe = 1'b0;
    int hold_at = 0, hold_len = 0, hold_pct = 0, hold_left = 0;
    int drop_last = 0, extra_left = 0;

    scen_t tbl [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_word();
        return 64'({busy_o, frame_done_o, err_timeout_o, rd_en_o, rd_addr_o,
                    cam_red_o, cam_green_o, cam_blue_o, cam_done_o,
                    wr_en_o, wr_addr_o, wr_data_o});
    endfunction

    // One clock: observe outputs just after the edge, update the frame-buffer
    // and pipeline models, then drive the inputs for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;

        if (rd_en_o) begin
            chk("rd_addr_seq", 64'(rd_addr_o), 64'(n_reads));
            chk("rd_en_under_hold", 64'(hold_i), 64'(0));
            if (n_reads > 0 && gap > max_gap) max_gap = gap;
            gap = 0;
            rd_cyc.push_back(cyc);
            last_addr     = int'(rd_addr_o);
            last_read_cyc = cyc;
            n_reads++;
            if (hold_len > 0 && n_reads == hold_at) hold_left = hold_len;
        end else begin
            chk("rd_addr_hold", 64'(rd_addr_o), 64'(last_addr));
            gap++;
        end

        rd_data_i  = prev_rd_en ? mem[prev_addr % N] : 24'($urandom);
        prev_rd_en = rd_en_o;
        prev_addr  = int'(rd_addr_o);

        if (cam_done_o) begin
            if (n_cam < N) begin
                chk("cam_red",   64'(cam_red_o),   64'(mem[n_cam][23:16]));
                chk("cam_green", 64'(cam_green_o), 64'(mem[n_cam][15:8]));
                chk("cam_blue",  64'(cam_blue_o),  64'(mem[n_cam][7:0]));
            end
            if (n_cam < rd_cyc.size())
                chk("cam_latency", 64'(cyc - rd_cyc[n_cam]), 64'(2));
            else
                chk("cam_without_read", 64'(n_cam), 64'(rd_cyc.size() - 1));
            if (n_cam < N - drop_last) pq.push_back('{cyc + 5, cam_red_o});
            n_cam++;
        end

        if (wr_en_o) begin
            if (n_wr < N) begin
                chk("wr_addr", 64'(wr_addr_o), 64'(n_wr));
                chk("wr_data", 64'(wr_data_o), 64'(mem[n_wr][23:16]));
            end else begin
                chk("wr_beyond_frame", 64'(n_wr), 64'(N - 1));
            end
            n_wr++;
            last_wr_cyc = cyc;
        end

        if (frame_done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (err_timeout_o && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
        end

        sobel_done_i = 1'b0;
        sobel_red_i  = 8'($urandom);
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            sobel_done_i = 1'b1;
            sobel_red_i  = pq[0].val;
            void'(pq.pop_front());
        end else if (extra_left > 0 && drop_last == 0 && n_cam == N && pq.size() == 0) begin
            sobel_done_i = 1'b1;
            extra_left--;
        end
        if (idle_strobe) begin
            sobel_done_i = 1'b1;
            idle_strobe  = 1'b0;
        end

        if (hold_pct > 0) begin
            hold_i = ($urandom_range(0, 99) < hold_pct);
        end else begin
            hold_i = (hold_left > 0);
            if (hold_left > 0) hold_left--;
        end
    endtask

    task automatic frame_reset();
        n_reads = 0; n_cam = 0; n_wr = 0; n_done = 0;
        gap = 0; max_gap = 0; err_seen = 1'b0; hold_left = 0;
        last_read_cyc = 0; last_wr_cyc = 0; done_cyc = 0; err_cyc = 0;
        pq.delete();
        rd_cyc.delete();
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    endtask

    task automatic run_frame(input scen_t s, input string tag);
        bit finished;
        frame_reset();
        hold_at    = s.hold_at;
        hold_len   = s.hold_len;
        hold_pct   = s.hold_pct;
        drop_last  = s.drop_last;
        extra_left = s.extra_after;

        start_i = 1'b1;
        step();
        start_i = s.start_busy;
        chk({tag, "_busy_after_start"}, 64'(busy_o), 64'(1));
        chk({tag, "_err_cleared_by_start"}, 64'(err_timeout_o), 64'(0));

        finished = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            step();
            if (frame_done_o) start_i = 1'b0;
            finished = (n_done > 0) || err_seen;
        end
        if (!finished) chk({tag, "_frame_end_bound"}, 64'(n_done), 64'(s.exp_done));
        start_i = 1'b0;

        if (s.exp_done > 0) begin
            chk({tag, "_done_after_last_wr"}, 64'(done_cyc - last_wr_cyc), 64'(1));
            chk({tag, "_busy_at_done"}, 64'(busy_o), 64'(0));
        end
        if (s.exp_err) begin
            chk({tag, "_timeout_after_drain"}, 64'(err_cyc - last_read_cyc), 64'(TMO));
            chk({tag, "_busy_at_timeout"}, 64'(busy_o), 64'(0));
        end

        repeat (15) step();
        if (s.extra_idle) idle_strobe = 1'b1;
        repeat (4) step();

        chk({tag, "_reads"},  64'(n_reads), 64'(N));
        chk({tag, "_cam"},    64'(n_cam),   64'(N));
        chk({tag, "_writes"}, 64'(n_wr),    64'(s.exp_writes));
        chk({tag, "_done"},   64'(n_done),  64'(s.exp_done));
        chk({tag, "_err"},    64'(err_timeout_o), 64'(s.exp_err));
        chk({tag, "_idle"},   64'(busy_o),  64'(0));
        if (s.hold_pct == 0)
            chk({tag, "_rd_gap"}, 64'(max_gap), 64'(s.hold_len));
    endtask

    initial begin
        scen_t s;
        //               hold_at len pct drop extra idle busy  wr done err
        tbl[0] = '{0, 0,  0, 0, 0, 1'b0, 1'b0, 12, 1, 1'b0};
        tbl[1] = '{5, 3,  0, 0, 0, 1'b0, 1'b0, 12, 1, 1'b0};
        tbl[2] = '{0, 0,  0, 2, 0, 1'b0, 1'b0, 10, 0, 1'b1};
        tbl[3] = '{0, 0,  0, 0, 2, 1'b1, 1'b0, 12, 1, 1'b0};
        tbl[4] = '{0, 0, 30, 0, 0, 1'b0, 1'b0, 12, 1, 1'b0};
        tbl[5] = '{0, 0, 50, 1, 0, 1'b0, 1'b0, 11, 0, 1'b1};
        tbl[6] = '{0, 0,  0, 0, 0, 1'b0, 1'b1, 12, 1, 1'b0};

        rst          = 1'b0;
        start_i      = 1'b0;
        hold_i       = 1'b0;
        rd_data_i    = '0;
        sobel_red_i  = '0;
        sobel_done_i = 1'b0;
        #3;
        chk("reset_outputs", outs_word(), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        chk("idle_without_start", 64'({busy_o, rd_en_o, wr_en_o}), 64'(0));

        for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 4; r++) begin
            s.hold_at     = 0;
            s.hold_len    = 0;
            s.hold_pct    = $urandom_range(10, 70);
            s.drop_last   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            s.extra_after = $urandom_range(0, 2);
            s.extra_idle  = 1'($urandom_range(0, 1));
            s.start_busy  = 1'($urandom_range(0, 1));
            s.exp_writes  = N - s.drop_last;
            s.exp_done    = (s.drop_last == 0) ? 1 : 0;
            s.exp_err     = (s.drop_last != 0);
            run_frame(s, $sformatf("rnd%0d", r));
        end

        // Reset asserted at the 7th read, then a clean frame from address 0.
        frame_reset();
        hold_pct = 0; hold_len = 0; drop_last = 0; extra_left = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 60 && n_reads < 7; k++) step();
        chk("rst_reached_7th_read", 64'(n_reads), 64'(7));
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", outs_word(), 64'(0));
        sobel_done_i = 1'b0;
        hold_i       = 1'b0;
        pq.delete();
        prev_rd_en = 1'b0;
        last_addr  = 0;
        repeat (2) @(negedge clk);
        chk("rst_held_outputs", outs_word(), 64'(0));
        rst = 1'b1;
        run_frame(tbl[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
